// File: rtl/vx_lsu_rsp_merge.sv
// vx_lsu_rsp_merge
// Coalesces partial LSU load-response beats into one full-warp commit per load.
// Each LSU tag owns a merge entry (open flag, lane mask, lane data, metadata).
// Non-eop beats accumulate into their tag's entry; an eop beat folds the entry
// and the beat into the single output register and closes the entry.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_ready     partial beat handshake
//   in_tag                LSU tag selecting the merge entry
//   in_wid/pc/rd/wb       load metadata (taken from the first beat of a load)
//   in_tmask/in_data      lanes carried by this beat and their data
//   in_eop                last beat of the load
//   out_valid/out_ready   merged commit handshake
//   out_wid/pc/rd/wb      metadata of the merged load
//   out_tmask/out_data    union of beat masks and merged lane data
//   out_eop               always 1
//   busy                  any entry open or output holding a result
module vx_lsu_rsp_merge #(
    parameter int NUM_THREADS = 4,
    parameter int NW_BITS     = 2,
    parameter int NR_BITS     = 5,
    parameter int TAG_BITS    = 2
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [TAG_BITS-1:0]      in_tag,
    input  logic [NW_BITS-1:0]       in_wid,
    input  logic [31:0]              in_pc,
    input  logic [NR_BITS-1:0]       in_rd,
    input  logic                     in_wb,
    input  logic [NUM_THREADS-1:0]   in_tmask,
    input  logic [NUM_THREADS*32-1:0] in_data,
    input  logic                     in_eop,

    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NW_BITS-1:0]       out_wid,
    output logic [31:0]              out_pc,
    output logic [NR_BITS-1:0]       out_rd,
    output logic                     out_wb,
    output logic [NUM_THREADS-1:0]   out_tmask,
    output logic [NUM_THREADS*32-1:0] out_data,
    output logic                     out_eop,

    output logic                     busy
);

    localparam int NUM_ENTRIES = 1 << TAG_BITS;
    localparam int DW          = NUM_THREADS * 32;

    // Merge entries
    logic [NUM_ENTRIES-1:0] open_q;
    logic [NUM_THREADS-1:0] acc_mask_q [NUM_ENTRIES];
    logic [DW-1:0]          acc_data_q [NUM_ENTRIES];
    logic [NW_BITS-1:0]     meta_wid_q [NUM_ENTRIES];
    logic [31:0]            meta_pc_q  [NUM_ENTRIES];
    logic [NR_BITS-1:0]     meta_rd_q  [NUM_ENTRIES];
    logic                   meta_wb_q  [NUM_ENTRIES];

    // Output register
    logic                   out_valid_q;
    logic [NW_BITS-1:0]     out_wid_q;
    logic [31:0]            out_pc_q;
    logic [NR_BITS-1:0]     out_rd_q;
    logic                   out_wb_q;
    logic [NUM_THREADS-1:0] out_tmask_q;
    logic [DW-1:0]          out_data_q;

    logic                   entry_open;
    logic [NUM_THREADS-1:0] merged_mask;
    logic [DW-1:0]          merged_data;
    logic [DW-1:0]          lane_sel;
    logic                   fire_beat;
    logic                   fire_eop;

    always_comb begin
        lane_sel = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            lane_sel[i*32 +: 32] = {32{in_tmask[i]}};
        end
        entry_open = open_q[in_tag];
        // Accumulators are cleared on close, so a closed entry contributes nothing.
        merged_mask = (entry_open ? acc_mask_q[in_tag] : '0) | in_tmask;
        merged_data = (in_data & lane_sel)
                    | ((entry_open ? acc_data_q[in_tag] : '0) & ~lane_sel);
        // Only eop beats need the output register; partial beats always land.
        in_ready  = ~in_eop | ~out_valid_q | out_ready;
        fire_beat = in_valid & in_ready & ~in_eop;
        fire_eop  = in_valid & in_ready & in_eop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            open_q <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                acc_mask_q[i] <= '0;
                acc_data_q[i] <= '0;
                meta_wid_q[i] <= '0;
                meta_pc_q[i]  <= '0;
                meta_rd_q[i]  <= '0;
                meta_wb_q[i]  <= 1'b0;
            end
        end else if (fire_beat) begin
            open_q[in_tag]     <= 1'b1;
            acc_mask_q[in_tag] <= merged_mask;
            acc_data_q[in_tag] <= merged_data;
            if (!entry_open) begin
                meta_wid_q[in_tag] <= in_wid;
                meta_pc_q[in_tag]  <= in_pc;
                meta_rd_q[in_tag]  <= in_rd;
                meta_wb_q[in_tag]  <= in_wb;
            end
        end else if (fire_eop) begin
            open_q[in_tag]     <= 1'b0;
            acc_mask_q[in_tag] <= '0;
            acc_data_q[in_tag] <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_wid_q   <= '0;
            out_pc_q    <= '0;
            out_rd_q    <= '0;
            out_wb_q    <= 1'b0;
            out_tmask_q <= '0;
            out_data_q  <= '0;
        end else if (fire_eop) begin
            out_valid_q <= 1'b1;
            out_wid_q   <= entry_open ? meta_wid_q[in_tag] : in_wid;
            out_pc_q    <= entry_open ? meta_pc_q[in_tag]  : in_pc;
            out_rd_q    <= entry_open ? meta_rd_q[in_tag]  : in_rd;
            out_wb_q    <= entry_open ? meta_wb_q[in_tag]  : in_wb;
            out_tmask_q <= merged_mask;
            out_data_q  <= merged_data;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_wid   = out_wid_q;
    assign out_pc    = out_pc_q;
    assign out_rd    = out_rd_q;
    assign out_wb    = out_wb_q;
    assign out_tmask = out_tmask_q;
    assign out_data  = out_data_q;
    assign out_eop   = 1'b1;
    assign busy      = out_valid_q | (|open_q);

endmodule

// File: tb/tb_vx_lsu_rsp_merge.sv
module tb_vx_lsu_rsp_merge;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_tag;
    logic [1:0]   in_wid;
    logic [31:0]  in_pc;
    logic [4:0]   in_rd;
    logic         in_wb;
    logic [3:0]   in_tmask;
    logic [127:0] in_data;
    logic         in_eop;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_wid;
    logic [31:0]  out_pc;
    logic [4:0]   out_rd;
    logic         out_wb;
    logic [3:0]   out_tmask;
    logic [127:0] out_data;
    logic         out_eop;
    logic         busy;

    int errors = 0;
    int checks = 0;

    vx_lsu_rsp_merge #(
        .NUM_THREADS(4),
        .NW_BITS(2),
        .NR_BITS(5),
        .TAG_BITS(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_tag(in_tag),
        .in_wid(in_wid),
        .in_pc(in_pc),
        .in_rd(in_rd),
        .in_wb(in_wb),
        .in_tmask(in_tmask),
        .in_data(in_data),
        .in_eop(in_eop),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_wid(out_wid),
        .out_pc(out_pc),
        .out_rd(out_rd),
        .out_wb(out_wb),
        .out_tmask(out_tmask),
        .out_data(out_data),
        .out_eop(out_eop),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock; outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] tag, input logic [1:0] wid, input logic [4:0] rd,
                         input logic [31:0] pc, input logic [3:0] tmask,
                         input logic [127:0] data, input logic eop);
        in_valid = 1'b1;
        in_tag   = tag;
        in_wid   = wid;
        in_rd    = rd;
        in_pc    = pc;
        in_wb    = 1'b1;
        in_tmask = tmask;
        in_data  = data;
        in_eop   = eop;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0; in_tag = '0; in_wid = '0; in_pc = '0; in_rd = '0;
        in_wb = 1'b0; in_tmask = '0; in_data = '0; in_eop = 1'b0; out_ready = 1'b1;
        tick(); tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++;
        if (out_eop !== 1'b1) begin errors++; $display("FAIL reset_out_eop got=%b want=1", out_eop); end
        checks++;
        if ({out_tmask, out_data, out_wid, out_pc, out_rd, out_wb} !== '0) begin
            errors++;
            $display("FAIL reset_out_fields tmask=%h data=%h wid=%h pc=%h rd=%h wb=%b want all 0",
                     out_tmask, out_data, out_wid, out_pc, out_rd, out_wb);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_beat();
        out_ready = 1'b1;
        drive(2'd1, 2'd2, 5'd5, 32'h100, 4'b1111, {32'd4, 32'd3, 32'd2, 32'd1}, 1'b1);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready got=%b want=1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got=%b want=1", out_valid); end
        checks++;
        if (out_tmask !== 4'b1111) begin errors++; $display("FAIL single_tmask got=%b want=1111", out_tmask); end
        checks++;
        if (out_data !== {32'd4, 32'd3, 32'd2, 32'd1}) begin
            errors++; $display("FAIL single_data got=%h want=%h", out_data, {32'd4, 32'd3, 32'd2, 32'd1});
        end
        checks++;
        if (out_wid !== 2'd2 || out_rd !== 5'd5 || out_pc !== 32'h100 || out_wb !== 1'b1) begin
            errors++;
            $display("FAIL single_meta got wid=%0d rd=%0d pc=%h wb=%b want wid=2 rd=5 pc=100 wb=1",
                     out_wid, out_rd, out_pc, out_wb);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL single_drain got valid=%b busy=%b want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_two_beat();
        out_ready = 1'b1;
        drive(2'd0, 2'd1, 5'd7, 32'h200, 4'b0011, {32'd0, 32'd0, 32'hB, 32'hA}, 1'b0);
        tick();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL two_first_beat got valid=%b busy=%b want 0 1", out_valid, busy);
        end
        // Different metadata on the eop beat must be ignored for an open entry.
        drive(2'd0, 2'd3, 5'd9, 32'h300, 4'b1100, {32'hD, 32'hC, 32'd0, 32'd0}, 1'b1);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_tmask !== 4'b1111) begin
            errors++; $display("FAIL two_out got valid=%b tmask=%b want 1 1111", out_valid, out_tmask);
        end
        checks++;
        if (out_data !== {32'hD, 32'hC, 32'hB, 32'hA}) begin
            errors++; $display("FAIL two_data got=%h want=%h", out_data, {32'hD, 32'hC, 32'hB, 32'hA});
        end
        checks++;
        if (out_wid !== 2'd1 || out_rd !== 5'd7 || out_pc !== 32'h200) begin
            errors++;
            $display("FAIL two_meta got wid=%0d rd=%0d pc=%h want wid=1 rd=7 pc=200", out_wid, out_rd, out_pc);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL two_drain got valid=%b busy=%b want 0 0", out_valid, busy);
        end
    endtask

    // Also exercises back-to-back eop beats with no output bubble.
    task automatic test_interleaved();
        out_ready = 1'b1;
        drive(2'd0, 2'd0, 5'd1, 32'h10, 4'b0001, {96'd0, 32'h100}, 1'b0);
        tick();
        drive(2'd1, 2'd1, 5'd2, 32'h20, 4'b0010, {64'd0, 32'h201, 32'd0}, 1'b0);
        tick();
        drive(2'd0, 2'd3, 5'd30, 32'h99, 4'b0010, {64'd0, 32'h101, 32'd0}, 1'b1);
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_tmask !== 4'b0011 || out_wid !== 2'd0 || out_rd !== 5'd1
            || out_data !== {64'd0, 32'h101, 32'h100}) begin
            errors++;
            $display("FAIL inter_first got valid=%b tmask=%b wid=%0d rd=%0d data=%h want 1 0011 0 1 %h",
                     out_valid, out_tmask, out_wid, out_rd, out_data, {64'd0, 32'h101, 32'h100});
        end
        drive(2'd1, 2'd3, 5'd31, 32'h98, 4'b0001, {96'd0, 32'h200}, 1'b1);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL inter_b2b_ready got=%b want=1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_tmask !== 4'b0011 || out_wid !== 2'd1 || out_rd !== 5'd2
            || out_data !== {64'd0, 32'h201, 32'h200}) begin
            errors++;
            $display("FAIL inter_second got valid=%b tmask=%b wid=%0d rd=%0d data=%h want 1 0011 1 2 %h",
                     out_valid, out_tmask, out_wid, out_rd, out_data, {64'd0, 32'h201, 32'h200});
        end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(2'd2, 2'd2, 5'd12, 32'h40, 4'b1111, {32'h44, 32'h43, 32'h42, 32'h41}, 1'b1);
        tick();
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_fill got=%b want=1", out_valid); end
        drive(2'd3, 2'd3, 5'd13, 32'h50, 4'b0001, {96'd0, 32'h55}, 1'b1);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_eop_ready got=%b want=0", in_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_rd !== 5'd12 || out_data !== {32'h44, 32'h43, 32'h42, 32'h41}) begin
            errors++; $display("FAIL bp_hold got valid=%b rd=%0d data=%h want 1 12 held", out_valid, out_rd, out_data);
        end
        drive(2'd0, 2'd1, 5'd14, 32'h60, 4'b0010, {64'd0, 32'h66, 32'd0}, 1'b0);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_beat_ready got=%b want=1", in_ready); end
        tick();
        drive(2'd3, 2'd3, 5'd13, 32'h50, 4'b0001, {96'd0, 32'h55}, 1'b1);
        #1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b want=1", in_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_rd !== 5'd13 || out_tmask !== 4'b0001 || out_data !== {96'd0, 32'h55}) begin
            errors++;
            $display("FAIL bp_reload got valid=%b rd=%0d tmask=%b data=%h want 1 13 0001 %h",
                     out_valid, out_rd, out_tmask, out_data, {96'd0, 32'h55});
        end
        drive(2'd0, 2'd2, 5'd20, 32'h70, 4'b0001, {96'd0, 32'h77}, 1'b1);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_tmask !== 4'b0011 || out_rd !== 5'd14 || out_data !== {64'd0, 32'h66, 32'h77}) begin
            errors++;
            $display("FAIL bp_other_tag got tmask=%b rd=%0d data=%h want 0011 14 %h",
                     out_tmask, out_rd, out_data, {64'd0, 32'h66, 32'h77});
        end
        tick();
    endtask

    task automatic test_overlap();
        out_ready = 1'b1;
        drive(2'd3, 2'd1, 5'd3, 32'h80, 4'b0001, {96'd0, 32'h11}, 1'b0);
        tick();
        drive(2'd3, 2'd1, 5'd3, 32'h80, 4'b0001, {96'd0, 32'h22}, 1'b1);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_tmask !== 4'b0001 || out_data !== {96'd0, 32'h22}) begin
            errors++;
            $display("FAIL overlap got valid=%b tmask=%b data=%h want 1 0001 %h",
                     out_valid, out_tmask, out_data, {96'd0, 32'h22});
        end
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        drive(2'd2, 2'd3, 5'd25, 32'h90, 4'b0001, {96'd0, 32'h99}, 1'b0);
        tick();
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_open_busy got=%b want=1", busy); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_cleared got busy=%b valid=%b want 0 0", busy, out_valid);
        end
        drive(2'd2, 2'd1, 5'd4, 32'hA0, 4'b1000, {32'h7, 96'd0}, 1'b1);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_tmask !== 4'b1000 || out_data !== {32'h7, 96'd0}
            || out_wid !== 2'd1 || out_rd !== 5'd4) begin
            errors++;
            $display("FAIL rstmid_out got valid=%b tmask=%b data=%h wid=%0d rd=%0d want 1 1000 %h 1 4",
                     out_valid, out_tmask, out_data, out_wid, out_rd, {32'h7, 96'd0});
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_two_beat();
        test_interleaved();
        test_backpressure();
        test_overlap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
